pipeline_switch_ctrl: RTL and testbench

- Parametrised pipeline-control block for the RISC-V core. Replaces the ad-hoc hold/reset wiring scattered across the IF/ID/EX/MEM pipeline registers with one source of per-stage hold/flush.
- Adds an OS-initiated cache-bank switch sequence that drains the pipeline, hands off to the caches, and resumes fetch.
- Sits beside the hazard, flush and forwarding units at CPU top level. Drives the PC register and every pipeline register.

---
 rtl/pipeline_switch_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_pipeline_switch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_switch_ctrl.sv
// Pipeline control: one source of per-stage hold/flush/valid for the
// IF/ID/EX/MEM registers plus the OS-initiated cache-bank switch sequence
// (drain pipeline, hand off to caches, resume fetch).
module pipeline_switch_ctrl #(
    parameter int NUM_STAGES     = 4,
    parameter int REDIRECT_STAGE = 2,
    parameter int HAZ_STAGE      = 1,
    parameter int BANK_BITS      = 2,
    parameter int SWITCH_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  imem_busywait,
    input  logic                  dmem_busywait,
    input  logic                  load_use_hazard,
    input  logic                  redirect,
    input  logic                  switch_cmd,
    input  logic [BANK_BITS-1:0]  switch_cmd_bank,
    input  logic                  switch_ack,
    output logic                  pc_hold,
    output logic [NUM_STAGES-1:0] stage_hold,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  switch_req,
    output logic [BANK_BITS-1:0]  switch_bank,
    output logic [BANK_BITS-1:0]  active_bank,
    output logic                  switch_busy,
    output logic                  switch_done,
    output logic                  switch_err
);

    localparam int CNT_W = $clog2(SWITCH_TIMEOUT + 1);

    // Registers younger than the redirect point are squashed on a redirect.
    localparam logic [NUM_STAGES-1:0] REDIR_MASK =
        NUM_STAGES'((32'd1 << REDIRECT_STAGE) - 32'd1);
    // Registers younger than the bubble point hold on a load-use hazard.
    localparam logic [NUM_STAGES-1:0] HAZ_HOLD_MASK =
        NUM_STAGES'((32'd1 << HAZ_STAGE) - 32'd1);
    // The bubble is inserted into the hazard register itself.
    localparam logic [NUM_STAGES-1:0] HAZ_FLUSH_MASK =
        NUM_STAGES'(32'd1 << HAZ_STAGE);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_RESUME = 2'd3
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [NUM_STAGES-1:0]  stage_valid_r, stage_valid_nxt_s;
    logic [BANK_BITS-1:0]   switch_bank_r, switch_bank_nxt_s;
    logic [BANK_BITS-1:0]   active_bank_r, active_bank_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic                   switch_req_r, switch_req_nxt_s;
    logic                   switch_done_r, switch_done_nxt_s;
    logic                   switch_err_r, switch_err_nxt_s;

    logic                   stall_s;
    logic                   pc_hold_s;
    logic [NUM_STAGES-1:0]  stage_hold_s;
    logic [NUM_STAGES-1:0]  stage_flush_s;

    assign stall_s = imem_busywait | dmem_busywait;

    // Per-stage hold/flush and PC hold derived from state and hazard inputs.
    always_comb begin
        pc_hold_s     = 1'b0;
        stage_hold_s  = '0;
        stage_flush_s = '0;
        if (stall_s) begin
            pc_hold_s    = 1'b1;
            stage_hold_s = '1;
        end else begin
            if (redirect) begin
                stage_flush_s = REDIR_MASK;
            end else if (load_use_hazard) begin
                pc_hold_s     = 1'b1;
                stage_hold_s  = HAZ_HOLD_MASK;
                stage_flush_s = HAZ_FLUSH_MASK;
            end else begin
                stage_flush_s = '0;
            end
            case (state_r)
                ST_RUN: begin
                    pc_hold_s = pc_hold_s;
                end
                ST_DRAIN: begin
                    // Keep bubbling fetch; a late redirect may still steer the PC.
                    stage_flush_s[0] = 1'b1;
                    pc_hold_s        = ~redirect;
                end
                ST_SWITCH, ST_RESUME: begin
                    stage_flush_s[0] = 1'b1;
                    pc_hold_s        = 1'b1;
                end
                default: begin
                    stage_flush_s[0] = 1'b1;
                    pc_hold_s        = 1'b1;
                end
            endcase
            // A flushed register loads a bubble, so it never also holds.
            stage_hold_s = stage_hold_s & ~stage_flush_s;
        end
    end

    // Next valid bits: frozen on stall, cleared on flush, shifted on advance.
    always_comb begin
        stage_valid_nxt_s = stage_valid_r;
        if (stall_s) begin
            stage_valid_nxt_s = stage_valid_r;
        end else begin
            if (stage_flush_s[0]) begin
                stage_valid_nxt_s[0] = 1'b0;
            end else if (stage_hold_s[0]) begin
                stage_valid_nxt_s[0] = stage_valid_r[0];
            end else begin
                stage_valid_nxt_s[0] = (state_r == ST_RUN);
            end
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (stage_flush_s[k]) begin
                    stage_valid_nxt_s[k] = 1'b0;
                end else if (stage_hold_s[k]) begin
                    stage_valid_nxt_s[k] = stage_valid_r[k];
                end else begin
                    stage_valid_nxt_s[k] = stage_valid_r[k-1];
                end
            end
        end
    end

    // Bank-switch FSM next state, timeout counter and status pulses.
    always_comb begin
        state_nxt_s       = state_r;
        switch_bank_nxt_s = switch_bank_r;
        active_bank_nxt_s = active_bank_r;
        cnt_nxt_s         = cnt_r;
        switch_req_nxt_s  = switch_req_r;
        switch_done_nxt_s = 1'b0;
        switch_err_nxt_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                // A stalled command pulse stays visible in MEM, so take it once unstalled.
                if (!stall_s && switch_cmd) begin
                    if (switch_cmd_bank == active_bank_r) begin
                        switch_done_nxt_s = 1'b1;
                    end else begin
                        switch_bank_nxt_s = switch_cmd_bank;
                        state_nxt_s       = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!stall_s && (stage_valid_r == '0)) begin
                    state_nxt_s      = ST_SWITCH;
                    switch_req_nxt_s = 1'b1;
                    cnt_nxt_s        = '0;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_SWITCH: begin
                // Counter and ack keep working through a stall; ack beats timeout.
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (switch_ack) begin
                    active_bank_nxt_s = switch_bank_r;
                    switch_done_nxt_s = 1'b1;
                    switch_req_nxt_s  = 1'b0;
                    state_nxt_s       = ST_RESUME;
                end else if (cnt_r == CNT_W'(SWITCH_TIMEOUT - 1)) begin
                    switch_err_nxt_s = 1'b1;
                    switch_req_nxt_s = 1'b0;
                    state_nxt_s      = ST_RESUME;
                end else begin
                    state_nxt_s = ST_SWITCH;
                end
            end
            ST_RESUME: begin
                cnt_nxt_s = '0;
                if (!stall_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_RESUME;
                end
            end
            default: begin
                state_nxt_s      = ST_RUN;
                switch_req_nxt_s = 1'b0;
                cnt_nxt_s        = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_RUN;
            stage_valid_r <= '0;
            switch_bank_r <= '0;
            active_bank_r <= '0;
            cnt_r         <= '0;
            switch_req_r  <= 1'b0;
            switch_done_r <= 1'b0;
            switch_err_r  <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            stage_valid_r <= stage_valid_nxt_s;
            switch_bank_r <= switch_bank_nxt_s;
            active_bank_r <= active_bank_nxt_s;
            cnt_r         <= cnt_nxt_s;
            switch_req_r  <= switch_req_nxt_s;
            switch_done_r <= switch_done_nxt_s;
            switch_err_r  <= switch_err_nxt_s;
        end
    end

    assign pc_hold     = pc_hold_s;
    assign stage_hold  = stage_hold_s;
    assign stage_flush = stage_flush_s;
    assign stage_valid = stage_valid_r;
    assign switch_req  = switch_req_r;
    assign switch_bank = switch_bank_r;
    assign active_bank = active_bank_r;
    assign switch_busy = (state_r != ST_RUN);
    assign switch_done = switch_done_r;
    assign switch_err  = switch_err_r;

endmodule

// File: tb/tb_pipeline_switch_ctrl.sv
// Directed bench for pipeline_switch_ctrl: vector table for hold/flush/valid,
// hand-written sequences for the bank-switch corner cases.
module tb_pipeline_switch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_busywait, dmem_busywait, load_use_hazard, redirect;
    logic       switch_cmd, switch_ack;
    logic [1:0] switch_cmd_bank;
    logic       pc_hold;
    logic [3:0] stage_hold, stage_flush, stage_valid;
    logic       switch_req, switch_busy, switch_done, switch_err;
    logic [1:0] switch_bank, active_bank;

    int checks = 0;
    int errors = 0;

    pipeline_switch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .imem_busywait   (imem_busywait),
        .dmem_busywait   (dmem_busywait),
        .load_use_hazard (load_use_hazard),
        .redirect        (redirect),
        .switch_cmd      (switch_cmd),
        .switch_cmd_bank (switch_cmd_bank),
        .switch_ack      (switch_ack),
        .pc_hold         (pc_hold),
        .stage_hold      (stage_hold),
        .stage_flush     (stage_flush),
        .stage_valid     (stage_valid),
        .switch_req      (switch_req),
        .switch_bank     (switch_bank),
        .active_bank     (active_bank),
        .switch_busy     (switch_busy),
        .switch_done     (switch_done),
        .switch_err      (switch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem;
        logic       dmem;
        logic       haz;
        logic       redir;
        logic       exp_pc_hold;
        logic [3:0] exp_hold;
        logic [3:0] exp_flush;
        logic [3:0] exp_valid;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_busywait   = 1'b0;
        dmem_busywait   = 1'b0;
        load_use_hazard = 1'b0;
        redirect        = 1'b0;
        switch_cmd      = 1'b0;
        switch_cmd_bank = 2'd0;
        switch_ack      = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!switch_req && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, switch_req}, 32'd1);
    endtask

    initial begin
        int n;
        // imem dmem haz redir | pc_hold hold flush | valid after edge
        vecs[0]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111};
        vecs[1]  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0010, 4'b1101};
        vecs[2]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1011};
        vecs[3]  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0011, 4'b0100};
        vecs[4]  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0011, 4'b1000};
        vecs[5]  = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000};
        vecs[6]  = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000};
        vecs[7]  = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000};
        vecs[8]  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0011, 4'b0000};
        vecs[9]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001};
        vecs[10] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0011};
        vecs[11] = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0010, 4'b0101};
        vecs[12] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1011};
        vecs[13] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1011};
        vecs[14] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0111};

        // ---------------- reset and pipeline fill ----------------
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_valid", {28'd0, stage_valid}, 32'h0);
        chk("rst_pc_hold", {31'd0, pc_hold}, 32'h0);
        chk("rst_hold", {28'd0, stage_hold}, 32'h0);
        chk("rst_flush", {28'd0, stage_flush}, 32'h0);
        chk("rst_status", {26'd0, switch_req, switch_busy, switch_done, switch_err, active_bank}, 32'h0);
        chk("rst_switch_bank", {30'd0, switch_bank}, 32'h0);
        reset = 1'b1;
        tick();
        chk("fill_1", {28'd0, stage_valid}, 32'h1);
        tick();
        chk("fill_2", {28'd0, stage_valid}, 32'h3);
        tick();
        chk("fill_3", {28'd0, stage_valid}, 32'h7);
        tick();
        chk("fill_4", {28'd0, stage_valid}, 32'hF);

        // ---------------- vector table ----------------
        for (int i = 0; i < 15; i++) begin
            imem_busywait   = vecs[i].imem;
            dmem_busywait   = vecs[i].dmem;
            load_use_hazard = vecs[i].haz;
            redirect        = vecs[i].redir;
            #1;
            chk($sformatf("vec%0d_pc_hold", i), {31'd0, pc_hold}, {31'd0, vecs[i].exp_pc_hold});
            chk($sformatf("vec%0d_hold", i), {28'd0, stage_hold}, {28'd0, vecs[i].exp_hold});
            chk($sformatf("vec%0d_flush", i), {28'd0, stage_flush}, {28'd0, vecs[i].exp_flush});
            tick();
            chk($sformatf("vec%0d_valid", i), {28'd0, stage_valid}, {28'd0, vecs[i].exp_valid});
        end
        idle_inputs();

        // ---------------- switch to bank 1, no ack: timeout ----------------
        switch_cmd      = 1'b1;
        switch_cmd_bank = 2'd1;
        tick();
        switch_cmd = 1'b0;
        chk("to_busy", {31'd0, switch_busy}, 32'd1);
        chk("to_switch_bank", {30'd0, switch_bank}, 32'd1);
        chk("to_drain_flush0", {31'd0, stage_flush[0]}, 32'd1);
        wait_req("to_req_rise");
        n = 0;
        while (!switch_err && n < 100) begin
            tick();
            n++;
        end
        chk("to_err_delay", n, 32'd64);
        chk("to_req_dropped", {31'd0, switch_req}, 32'd0);
        chk("to_active_bank", {30'd0, active_bank}, 32'd0);
        chk("to_no_done", {31'd0, switch_done}, 32'd0);
        tick();
        chk("to_err_once", {31'd0, switch_err}, 32'd0);
        chk("to_back_run", {31'd0, switch_busy}, 32'd0);

        // ---------------- switch to bank 2 with ack ----------------
        tick();
        tick();
        switch_cmd      = 1'b1;
        switch_cmd_bank = 2'd2;
        tick();
        switch_cmd = 1'b0;
        chk("sw_switch_bank", {30'd0, switch_bank}, 32'd2);
        chk("sw_no_req_in_drain", {31'd0, switch_req}, 32'd0);
        n = 0;
        while (stage_valid != 4'b0000 && n < 10) begin
            tick();
            n++;
        end
        chk("sw_drained", {28'd0, stage_valid}, 32'h0);
        wait_req("sw_req_rise");
        chk("sw_pc_hold", {31'd0, pc_hold}, 32'd1);
        chk("sw_flush", {28'd0, stage_flush}, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        chk("sw_req_level", {31'd0, switch_req}, 32'd1);
        switch_ack = 1'b1;
        tick();
        switch_ack = 1'b0;
        chk("sw_active_bank", {30'd0, active_bank}, 32'd2);
        chk("sw_done", {31'd0, switch_done}, 32'd1);
        chk("sw_req_drop", {31'd0, switch_req}, 32'd0);
        chk("sw_resume_busy", {31'd0, switch_busy}, 32'd1);
        chk("sw_resume_flush0", {31'd0, stage_flush[0]}, 32'd1);
        tick();
        chk("sw_done_once", {31'd0, switch_done}, 32'd0);
        chk("sw_run", {31'd0, switch_busy}, 32'd0);

        // ---------------- same bank: immediate done ----------------
        switch_cmd      = 1'b1;
        switch_cmd_bank = 2'd2;
        tick();
        switch_cmd = 1'b0;
        chk("same_done", {31'd0, switch_done}, 32'd1);
        chk("same_no_req", {31'd0, switch_req}, 32'd0);
        chk("same_busy", {31'd0, switch_busy}, 32'd0);
        tick();
        chk("same_done_once", {31'd0, switch_done}, 32'd0);

        // ---------------- stalled command, then reset mid-switch ----------------
        dmem_busywait   = 1'b1;
        switch_cmd      = 1'b1;
        switch_cmd_bank = 2'd3;
        tick();
        chk("stl_cmd_wait1", {31'd0, switch_busy}, 32'd0);
        tick();
        chk("stl_cmd_wait2", {31'd0, switch_busy}, 32'd0);
        dmem_busywait = 1'b0;
        tick();
        switch_cmd = 1'b0;
        chk("stl_cmd_taken", {31'd0, switch_busy}, 32'd1);
        wait_req("rs_req_rise");
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rs_busy", {31'd0, switch_busy}, 32'd0);
        chk("rs_req", {31'd0, switch_req}, 32'd0);
        chk("rs_active_bank", {30'd0, active_bank}, 32'd0);
        chk("rs_pulses", {30'd0, switch_done, switch_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
